// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Serialises bytes onto the UART TX line, LSB first, line idles high.
//   Default frame is 8N1. Defining UART_TX_PARITY_EN inserts an even-parity
//   bit between the data bits and the stop bit (8E1).
//   Each bit lasts CLOCK_FREQ / BAUD_RATE clock cycles.
//
// Ports
//   clk            in   system clock, all state updates on posedge
//   rst_n          in   asynchronous active-low reset
//   data_in        in   byte to send, sampled only on an accept cycle
//   data_in_valid  in   source has a byte on data_in
//   data_in_ready  out  transmitter can take a byte (state == IDLE)
//   serial_out     out  registered UART TX line, 1 = idle/mark

module uart_transmitter #(
   parameter int unsigned CLOCK_FREQ = 125_000_000,
   parameter int unsigned BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_in_ready,
   output logic       serial_out
);

   localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             line_n;
   logic             bit_end;
   logic             accept;
`ifdef UART_TX_PARITY_EN
   logic             parity_bit;
`endif

   assign data_in_ready = (state == IDLE);
   assign accept        = data_in_valid & data_in_ready;
   assign bit_end       = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // The line value is computed for the state being entered and registered,
   // so serial_out changes on the same edge as the state and never glitches.
   always_comb begin
      state_n = state;
      line_n  = 1'b1;
      case (state)
         IDLE:  if (accept)  state_n = START;
         START: if (bit_end) state_n = DATA;
         DATA: begin
            if (bit_end && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               state_n = PARITY;
`else
               state_n = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) state_n = STOP;
`endif
         STOP:  if (bit_end) state_n = IDLE;
         default: state_n = IDLE;
      endcase

      case (state_n)
         START: line_n = 1'b0;
         // Within DATA, a bit end shifts the register on the same edge, so
         // the next bit to drive is shreg[1] rather than shreg[0].
         DATA:  line_n = ((state == DATA) && bit_end) ? shreg[1] : shreg[0];
`ifdef UART_TX_PARITY_EN
         PARITY: line_n = parity_bit;
`endif
         default: line_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         serial_out <= 1'b1;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         serial_out <= line_n;

         if ((state == IDLE) || bit_end) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end

         if (accept) begin
            shreg <= data_in;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^data_in;
`endif
         end else if ((state == DATA) && bit_end) begin
            shreg <= {1'b0, shreg[7:1]};
         end

         if ((state == START) && bit_end) begin
            bit_idx <= '0;
         end else if ((state == DATA) && bit_end && (bit_idx != 3'd7)) begin
            bit_idx <= bit_idx + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

   localparam int S = 10;            // 1000 Hz / 100 baud
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * S;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data_in = '0;
   logic       data_in_valid = 1'b0;
   logic       data_in_ready;
   logic       serial_out;

   int checks = 0;
   int fails = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int frames = 0;
   logic [7:0] exp_q[$];
   int acc_times[$];

   uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .data_in(data_in),
      .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready),
      .serial_out(serial_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference frame: start 0, data LSB first, optional even parity, stop 1.
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if ((NB == 11) && (k == 9)) return ^b;
      return 1'b1;
   endfunction

   // Stimulus side of the scoreboard: every handshake pushes the byte.
   always @(posedge clk) begin
      cyc++;
      if (rst_n && data_in_valid && data_in_ready) begin
         exp_q.push_back(data_in);
         acc_times.push_back(cyc);
         acc_cnt++;
      end
   end

   // Line monitor: decodes frames, requires every bit constant for S cycles.
   bit         mon_busy = 1'b0;
   int         idx = 0;
   int         kb = 0;
   bit         stable = 1'b1;
   logic       bv[0:10];
   logic [7:0] got;
   logic [7:0] e;

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_busy = 1'b0;
      end else begin
         if (!mon_busy && (serial_out === 1'b0)) begin
            mon_busy = 1'b1;
            idx = 0;
            stable = 1'b1;
         end
         if (mon_busy) begin
            kb = idx / S;
            if ((idx % S) == 0) bv[kb] = serial_out;
            else if (serial_out !== bv[kb]) stable = 1'b0;
            idx++;
            if (idx == FRAME) begin
               mon_busy = 1'b0;
               frames++;
               for (int i = 0; i < 8; i++) got[i] = bv[i+1];
               chk("frame_stable", 32'(stable), 32'd1);
               chk("stop_bit", 32'(bv[NB-1]), 32'd1);
               if (exp_q.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL unexpected_frame: got %0h expected none", got);
               end else begin
                  e = exp_q.pop_front();
                  chk("rx_byte", 32'(got), 32'(e));
                  if (NB == 11) chk("parity_bit", 32'(bv[9]), 32'(^e));
               end
            end
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!data_in_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("ready_timeout", 32'(data_in_ready), 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || mon_busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   // Cycle-exact check of one frame and of the ready signal.
   task automatic send_directed(input logic [7:0] b);
      int base;
      wait_ready();
      base = acc_cnt;
      data_in = b;
      data_in_valid = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= FRAME + 1; c++) begin
         @(negedge clk);
         if (c == 1) begin
            data_in_valid = 1'b0;
            data_in = ~b;
            chk("accepted", 32'(acc_cnt), 32'(base + 1));
         end
         if (c <= FRAME) begin
            chk("line_bit", 32'(serial_out), 32'(frame_bit(b, (c - 1) / S)));
            chk("ready_busy", 32'(data_in_ready), 32'd0);
         end else begin
            chk("line_idle", 32'(serial_out), 32'd1);
            chk("ready_back", 32'(data_in_ready), 32'd1);
         end
      end
      drain();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;

      // Reset state while held, then 200 idle cycles.
      repeat (3) @(negedge clk);
      chk("reset_line", 32'(serial_out), 32'd1);
      chk("reset_ready", 32'(data_in_ready), 32'd1);
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         chk("idle_line", 32'(serial_out), 32'd1);
         chk("idle_ready", 32'(data_in_ready), 32'd1);
      end

      send_directed(8'h55);

      // Back-to-back with valid held high.
      wait_ready();
      base = acc_cnt;
      data_in = 8'hA5;
      data_in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data_in = 8'h3C;
      n = 0;
      while (acc_cnt < base + 2 && n < 400) begin
         @(negedge clk);
         n++;
      end
      data_in_valid = 1'b0;
      chk("b2b_accepts", 32'(acc_cnt), 32'(base + 2));
      if (acc_cnt == base + 2)
         chk("b2b_gap", 32'(acc_times[acc_times.size()-1] - acc_times[acc_times.size()-2]),
             32'(FRAME + 1));
      drain();

      // Reset in the middle of data bit 3 of 0xFF.
      wait_ready();
      data_in = 8'hFF;
      data_in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data_in_valid = 1'b0;
      repeat (44) @(negedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("abort_line", 32'(serial_out), 32'd1);
      chk("abort_ready", 32'(data_in_ready), 32'd1);
      base = acc_cnt;
      data_in_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("no_accept_in_reset", 32'(acc_cnt), 32'(base));
      data_in_valid = 1'b0;
      rst_n = 1'b1;
      send_directed(8'h0F);

      // Parity-relevant patterns (also plain 8N1 frames when parity is off).
      send_directed(8'h07);
      send_directed(8'h03);

      // Random stalls, data churning while busy.
      for (int i = 0; i < 25; i++) begin
         repeat ($urandom_range(0, 25)) @(negedge clk);
         @(negedge clk);
         data_in_valid = 1'b1;
         data_in = 8'($urandom);
         base = acc_cnt;
         n = 0;
         while (acc_cnt == base && n < 300) begin
            @(negedge clk);
            data_in = 8'($urandom);
            n++;
         end
         chk("rand_accept", 32'(acc_cnt), 32'(base + 1));
         if ($urandom_range(0, 1) == 0) data_in_valid = 1'b0;
      end
      @(negedge clk);
      data_in_valid = 1'b0;
      // A held valid may have been taken on the edge just before it dropped.
      drain();
      chk("frames_vs_accepts", 32'(frames), 32'(acc_cnt - 1));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
